// File: rtl/sdio_pkg.sv
// Shared types and helpers for the SDIO receive word packer.
package sdio_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PACK  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int unsigned MAX_LANES = 64;

  function automatic int unsigned lanes_of(input int unsigned data_width);
    return data_width / 32'd8;
  endfunction

  // Thermometer mask with the low n lanes set; callers keep the lanes they have.
  function automatic logic [MAX_LANES-1:0] strb_mask(input int unsigned n);
    logic [MAX_LANES-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_LANES; i++) begin
      m[i] = (i < n);
    end
    return m;
  endfunction

endpackage

// File: rtl/sdio_rx_word_packer_if.sv
// Byte-in / word-out stream bundle between the CDC FIFO, the packer and the DMA path.
interface sdio_rx_word_packer_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LANES      = DATA_WIDTH / 32'd8
);

  logic [7:0]            in_data_i;
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [DATA_WIDTH-1:0] out_data_o;
  logic [LANES-1:0]      out_strb_o;
  logic                  out_last_o;
  logic                  out_valid_o;
  logic                  out_ready_i;

  modport slave (
    input  in_data_i, in_valid_i, out_ready_i,
    output in_ready_o, out_data_o, out_strb_o, out_last_o, out_valid_o
  );

  modport master (
    output in_data_i, in_valid_i, out_ready_i,
    input  in_ready_o, out_data_o, out_strb_o, out_last_o, out_valid_o
  );

endinterface

// File: rtl/sdio_rx_word_packer.sv
// Packs the CDC FIFO byte stream little-endian into words framed by a block length,
// with a single-entry output register that sustains one word per cycle.
module sdio_rx_word_packer
  import sdio_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BLK_LEN_W  = 12
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [BLK_LEN_W-1:0] blk_len_i,
  input  logic                 abort_i,
  output logic                 busy_o,
  output logic                 done_o,
  sdio_rx_word_packer_if.slave bus
);

  localparam int unsigned LANES  = lanes_of(DATA_WIDTH);
  localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned CNT_W  = BLK_LEN_W + 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      rem_q, rem_d;
  logic [LANE_W-1:0]     lane_q, lane_d;
  logic [DATA_WIDTH-1:0] pack_q, pack_d;
  logic [DATA_WIDTH-1:0] odata_q, odata_d;
  logic [LANES-1:0]      ostrb_q, ostrb_d;
  logic                  olast_q, olast_d;
  logic                  ovalid_q, ovalid_d;

  logic                  word_complete_s;
  logic                  slot_free_s;
  logic                  in_ready_s;
  logic                  in_fire_s;
  logic                  out_fire_s;
  logic [DATA_WIDTH-1:0] merged_s;
  logic [MAX_LANES-1:0]  strb_all_s;
  logic                  unused_strb_s;

  assign word_complete_s = (lane_q == LAST_LANE) || (rem_q == CNT_ONE);
  assign slot_free_s     = !ovalid_q || bus.out_ready_i;
  assign in_ready_s      = (state_q == PACK) && (!word_complete_s || slot_free_s);
  assign in_fire_s       = bus.in_valid_i && in_ready_s;
  assign out_fire_s      = ovalid_q && bus.out_ready_i;
  assign strb_all_s      = strb_mask(32'(lane_q) + 32'd1);
  assign unused_strb_s   = ^strb_all_s;

  // Current pack contents with the incoming byte dropped into its lane.
  always_comb begin
    merged_s = pack_q;
    for (int unsigned k = 0; k < LANES; k++) begin
      merged_s[8*k +: 8] = (lane_q == LANE_W'(k)) ? bus.in_data_i : pack_q[8*k +: 8];
    end
  end

  // Next-state logic for the framing FSM, the pack buffer and the output slot.
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    lane_d   = lane_q;
    pack_d   = pack_q;
    odata_d  = odata_q;
    ostrb_d  = ostrb_q;
    olast_d  = olast_q;
    ovalid_d = ovalid_q;

    if (abort_i) begin
      state_d  = IDLE;
      rem_d    = '0;
      lane_d   = '0;
      pack_d   = '0;
      odata_d  = '0;
      ostrb_d  = '0;
      olast_d  = 1'b0;
      ovalid_d = 1'b0;
    end else begin
      if (out_fire_s) begin
        odata_d  = '0;
        ostrb_d  = '0;
        olast_d  = 1'b0;
        ovalid_d = 1'b0;
      end else begin
        ovalid_d = ovalid_q;
      end

      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_d = PACK;
            rem_d   = (blk_len_i == '0) ? {1'b1, {BLK_LEN_W{1'b0}}} : {1'b0, blk_len_i};
            lane_d  = '0;
            pack_d  = '0;
          end else begin
            state_d = IDLE;
          end
        end
        PACK: begin
          if (in_fire_s) begin
            rem_d = rem_q - CNT_ONE;
            // A completing byte bypasses the pack buffer straight into the output slot.
            if (word_complete_s) begin
              lane_d   = '0;
              pack_d   = '0;
              odata_d  = merged_s;
              ostrb_d  = strb_all_s[LANES-1:0];
              olast_d  = (rem_q == CNT_ONE);
              ovalid_d = 1'b1;
            end else begin
              lane_d = lane_q + LANE_W'(1);
              pack_d = merged_s;
            end
            state_d = (rem_q == CNT_ONE) ? DRAIN : PACK;
          end else begin
            state_d = PACK;
          end
        end
        DRAIN: begin
          if (out_fire_s && olast_q) begin
            state_d = IDLE;
          end else begin
            state_d = DRAIN;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      lane_q   <= '0;
      pack_q   <= '0;
      odata_q  <= '0;
      ostrb_q  <= '0;
      olast_q  <= 1'b0;
      ovalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      lane_q   <= lane_d;
      pack_q   <= pack_d;
      odata_q  <= odata_d;
      ostrb_q  <= ostrb_d;
      olast_q  <= olast_d;
      ovalid_q <= ovalid_d;
    end
  end

  assign busy_o          = (state_q != IDLE);
  assign done_o          = (state_q == DRAIN) && out_fire_s && olast_q && !abort_i;
  assign bus.in_ready_o  = in_ready_s;
  assign bus.out_data_o  = odata_q;
  assign bus.out_strb_o  = ostrb_q;
  assign bus.out_last_o  = olast_q;
  assign bus.out_valid_o = ovalid_q;

endmodule
